seg_scan_display: RTL and testbench

Parametrised multi-digit, multi-channel 7-segment scan controller for board-level debug display. It replaces the fixed 4-digit/4-input select, transfer and decode chain with one block. Features:
- Configurable digit count, channel count and scan rate.
- Tear-free per-frame data snapshot.
- Per-digit blanking.
- Automatic channel cycling mode.

Sits between CPU debug buses and the board's segment/anode pins.

---
 rtl/seg_scan_display.sv | 137 +++++++++++++
 tb/tb_seg_scan_display.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_display.sv
// Multi-digit, multi-channel 7-segment scan controller. A channel word is
// snapshotted once per frame and each digit is then shown for SCAN_DIV cycles.
module seg_scan_display #(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned NUM_CHANNELS = 4,
  parameter int unsigned SCAN_DIV     = 100000,
  parameter int unsigned AUTO_DWELL   = 200,
  localparam int unsigned SEL_W       = $clog2(NUM_CHANNELS)
) (
  input  logic                                 CLK,
  input  logic                                 Reset,
  input  logic [NUM_CHANNELS*NUM_DIGITS*4-1:0] ChannelData,
  input  logic [SEL_W-1:0]                     SelectCode,
  input  logic                                 AutoMode,
  input  logic [NUM_DIGITS-1:0]                BlankMask,
  output logic [7:0]                           SegOut,
  output logic [NUM_DIGITS-1:0]                Bits,
  output logic [SEL_W-1:0]                     CurChannel,
  output logic                                 FrameTick
);
  localparam int unsigned WORD_W = NUM_DIGITS * 4;
  localparam int unsigned DIG_W  = $clog2(NUM_DIGITS);
  localparam int unsigned PRE_W  = $clog2(SCAN_DIV);
  localparam int unsigned DWL_W  = (AUTO_DWELL > 1) ? $clog2(AUTO_DWELL) : 1;

  logic [PRE_W-1:0]      r_presc;
  logic [DIG_W-1:0]      r_digit;
  logic [SEL_W-1:0]      r_chan;
  logic [DWL_W-1:0]      r_dwell;
  logic [WORD_W-1:0]     r_snap;

  logic                  w_tick;
  logic                  w_frame;
  logic [DIG_W-1:0]      w_digit_nxt;
  logic [SEL_W-1:0]      w_chan_nxt;
  logic [SEL_W-1:0]      w_chan_shown;
  logic [DWL_W-1:0]      w_dwell_nxt;
  logic [WORD_W-1:0]     w_snap_nxt;
  logic [3:0]            w_nibble;
  logic [7:0]            w_seg_nxt;
  logic [NUM_DIGITS-1:0] w_bits_nxt;

  function automatic logic [6:0] hex_decode(input logic [3:0] v);
    logic [6:0] seg;
    unique case (v)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
    endcase
    return seg;
  endfunction

  assign w_tick      = (r_presc == PRE_W'(SCAN_DIV - 1));
  assign w_frame     = w_tick && (r_digit == DIG_W'(NUM_DIGITS - 1));
  assign w_digit_nxt = (r_digit == DIG_W'(NUM_DIGITS - 1)) ? '0 : r_digit + DIG_W'(1);

  // Channel/dwell candidates; only committed on a frame boundary.
  always_comb begin
    w_chan_nxt  = r_chan;
    w_dwell_nxt = r_dwell;
    if (!AutoMode) begin
      w_chan_nxt  = (32'(SelectCode) < NUM_CHANNELS) ? SelectCode : '0;
      w_dwell_nxt = '0;
    end else if (r_dwell == DWL_W'(AUTO_DWELL - 1)) begin
      w_chan_nxt  = (r_chan == SEL_W'(NUM_CHANNELS - 1)) ? '0 : r_chan + SEL_W'(1);
      w_dwell_nxt = '0;
    end else begin
      w_dwell_nxt = r_dwell + DWL_W'(1);
    end
  end

  // Digit 0 of a new frame must already see the freshly loaded snapshot.
  always_comb begin
    w_chan_shown = w_frame ? w_chan_nxt : r_chan;
    w_snap_nxt   = r_snap;
    if (w_frame) begin
      for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
        if (w_chan_nxt == SEL_W'(c)) w_snap_nxt = ChannelData[c*WORD_W +: WORD_W];
      end
    end
    w_nibble = '0;
    for (int unsigned d = 0; d < NUM_DIGITS; d++) begin
      if (w_digit_nxt == DIG_W'(d)) w_nibble = w_snap_nxt[d*4 +: 4];
    end
    w_seg_nxt  = {1'b1, hex_decode(w_nibble)};
    w_bits_nxt = '1;
    if (32'(w_digit_nxt) == 32'(w_chan_shown)) w_seg_nxt[7] = 1'b0;
    for (int unsigned d = 0; d < NUM_DIGITS; d++) begin
      if (w_digit_nxt == DIG_W'(d)) begin
        w_bits_nxt[d] = 1'b0;
        if (BlankMask[d]) w_seg_nxt = 8'hFF;
      end
    end
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_presc   <= '0;
      r_digit   <= DIG_W'(NUM_DIGITS - 1);
      r_chan    <= '0;
      r_dwell   <= '0;
      r_snap    <= '0;
      SegOut    <= 8'hFF;
      Bits      <= '1;
      FrameTick <= 1'b0;
    end else begin
      r_presc   <= w_tick ? '0 : r_presc + PRE_W'(1);
      FrameTick <= w_frame;
      if (w_tick) begin
        r_digit <= w_digit_nxt;
        SegOut  <= w_seg_nxt;
        Bits    <= w_bits_nxt;
      end
      if (w_frame) begin
        r_chan  <= w_chan_nxt;
        r_dwell <= w_dwell_nxt;
        r_snap  <= w_snap_nxt;
      end
    end
  end

  assign CurChannel = r_chan;

endmodule

// File: tb/tb_seg_scan_display.sv
// Directed + randomized bench for seg_scan_display with a digit-level
// reference model; a second instance covers a non-power-of-two channel count.
module tb_seg_scan_display;
  localparam int ND  = 4;
  localparam int NC  = 4;
  localparam int SD  = 4;
  localparam int AD  = 2;
  localparam int NC3 = 3;

  logic              CLK = 1'b0;
  logic              Reset = 1'b0;
  logic [NC*ND*4-1:0] ChannelData;
  logic [1:0]        SelectCode;
  logic              AutoMode;
  logic [ND-1:0]     BlankMask;
  logic [7:0]        SegOut;
  logic [ND-1:0]     Bits;
  logic [1:0]        CurChannel;
  logic              FrameTick;

  logic [NC3*ND*4-1:0] cd3;
  logic [1:0]          sel3;
  logic [ND-1:0]       blank3;
  logic [7:0]          seg3;
  logic [ND-1:0]       bits3;
  logic [1:0]          cur3;
  logic                ft3;

  seg_scan_display #(
    .NUM_DIGITS(ND), .NUM_CHANNELS(NC), .SCAN_DIV(SD), .AUTO_DWELL(AD)
  ) u_dut (
    .CLK(CLK), .Reset(Reset), .ChannelData(ChannelData), .SelectCode(SelectCode),
    .AutoMode(AutoMode), .BlankMask(BlankMask), .SegOut(SegOut), .Bits(Bits),
    .CurChannel(CurChannel), .FrameTick(FrameTick)
  );

  seg_scan_display #(
    .NUM_DIGITS(ND), .NUM_CHANNELS(NC3), .SCAN_DIV(SD), .AUTO_DWELL(AD)
  ) u_dut3 (
    .CLK(CLK), .Reset(Reset), .ChannelData(cd3), .SelectCode(sel3),
    .AutoMode(1'b0), .BlankMask(blank3), .SegOut(seg3), .Bits(bits3),
    .CurChannel(cur3), .FrameTick(ft3)
  );

  always #5 CLK = ~CLK;

  int checks;
  int failures;
  int ft_seen;
  logic [6:0] hex7 [16];

  // Reference model state, advanced once per displayed digit.
  int         m_digit;
  int         m_chan;
  int         m_dwell;
  logic [15:0] m_snap;
  logic [7:0] m_seg;
  logic [3:0] m_bits;
  logic       m_ft;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_digit = ND - 1;
    m_chan  = 0;
    m_dwell = 0;
    m_snap  = '0;
    m_seg   = 8'hFF;
    m_bits  = 4'hF;
    m_ft    = 1'b0;
  endtask

  task automatic model_tick();
    logic [15:0] sh;
    m_digit = (m_digit + 1) % ND;
    m_ft    = (m_digit == 0);
    if (m_ft) begin
      if (!AutoMode) begin
        m_chan  = (int'(SelectCode) < NC) ? int'(SelectCode) : 0;
        m_dwell = 0;
      end else if (m_dwell == AD - 1) begin
        m_chan  = (m_chan + 1) % NC;
        m_dwell = 0;
      end else begin
        m_dwell++;
      end
      m_snap = ChannelData[m_chan*16 +: 16];
    end
    sh     = m_snap >> (4 * m_digit);
    m_bits = 4'hF & ~(4'h1 << m_digit);
    if (BlankMask[m_digit]) m_seg = 8'hFF;
    else m_seg = {(m_digit == m_chan) ? 1'b0 : 1'b1, hex7[sh[3:0]]};
  endtask

  // One digit period: SD-1 quiet edges then the scan tick edge.
  task automatic digit_step(input string tag);
    for (int i = 0; i < SD - 1; i++) begin
      @(posedge CLK);
      #1;
      ft_seen += int'(FrameTick);
      chk({tag, ":hold_seg"}, 32'(SegOut), 32'(m_seg));
      chk({tag, ":hold_bits"}, 32'(Bits), 32'(m_bits));
      chk({tag, ":hold_ft"}, 32'(FrameTick), 32'(0));
    end
    @(posedge CLK);
    model_tick();
    #1;
    ft_seen += int'(FrameTick);
    chk({tag, ":seg"}, 32'(SegOut), 32'(m_seg));
    chk({tag, ":bits"}, 32'(Bits), 32'(m_bits));
    chk({tag, ":cur"}, 32'(CurChannel), 32'(m_chan));
    chk({tag, ":ft"}, 32'(FrameTick), 32'(m_ft));
  endtask

  task automatic finish_frame();
    while (m_digit != ND - 1) digit_step("ff");
  endtask

  task automatic frame_12af(input string tag);
    digit_step({tag, "_d0"});
    chk({tag, "_d0_seg"}, 32'(SegOut), 32'h8E);
    chk({tag, "_d0_bits"}, 32'(Bits), 32'hE);
    digit_step({tag, "_d1"});
    chk({tag, "_d1_seg"}, 32'(SegOut), 32'h08);
    chk({tag, "_d1_bits"}, 32'(Bits), 32'hD);
    digit_step({tag, "_d2"});
    chk({tag, "_d2_seg"}, 32'(SegOut), 32'hA4);
    chk({tag, "_d2_bits"}, 32'(Bits), 32'hB);
    digit_step({tag, "_d3"});
    chk({tag, "_d3_seg"}, 32'(SegOut), 32'hF9);
    chk({tag, "_d3_bits"}, 32'(Bits), 32'h7);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "bench timed out");
  end

  initial begin
    int f0;
    int seq_obs [9];
    int seq_exp [9];
    hex7 = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    seq_exp = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
    checks   = 0;
    failures = 0;
    ft_seen  = 0;
    ChannelData = {$urandom, $urandom};
    ChannelData[31:16] = 16'h12AF;
    SelectCode = 2'd1;
    AutoMode   = 1'b0;
    BlankMask  = '0;
    cd3    = 48'({$urandom, $urandom});
    sel3   = 2'd3;
    blank3 = '0;

    #2 Reset = 1'b1;
    #1;
    chk("rst_seg", 32'(SegOut), 32'hFF);
    chk("rst_bits", 32'(Bits), 32'hF);
    chk("rst_cur", 32'(CurChannel), 32'h0);
    chk("rst_ft", 32'(FrameTick), 32'h0);
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_hold_seg", 32'(SegOut), 32'hFF);
    Reset = 1'b0;
    model_reset();

    // Basic frame, channel 1 = 12AF.
    f0 = ft_seen;
    frame_12af("s1");
    chk("s1_ft_per_frame", 32'(ft_seen - f0), 32'd1);

    // Mid-frame select/data change must wait for the next frame.
    digit_step("s2_d0");
    digit_step("s2_d1");
    SelectCode  = 2'd2;
    ChannelData = {$urandom, $urandom};
    digit_step("s2_d2");
    chk("s2_d2_oldsnap", 32'(SegOut), 32'hA4);
    chk("s2_d2_cur", 32'(CurChannel), 32'd1);
    digit_step("s2_d3");
    chk("s2_d3_oldsnap", 32'(SegOut), 32'hF9);
    digit_step("s2_next_d0");
    chk("s2_next_cur", 32'(CurChannel), 32'd2);

    // Randomized inputs changed at arbitrary digits.
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 2) == 0) begin
        ChannelData = {$urandom, $urandom};
        SelectCode  = 2'($urandom);
        AutoMode    = 1'($urandom_range(0, 1));
        BlankMask   = 4'($urandom);
      end
      digit_step("rnd");
    end

    // Auto cycling with dwell of two frames.
    AutoMode   = 1'b0;
    SelectCode = 2'd0;
    BlankMask  = '0;
    finish_frame();
    digit_step("au_m");
    seq_obs[0] = int'(CurChannel);
    AutoMode = 1'b1;
    repeat (3) digit_step("au");
    for (int f = 1; f < 9; f++) begin
      digit_step("au_f");
      seq_obs[f] = int'(CurChannel);
      repeat (3) digit_step("au");
    end
    for (int f = 0; f < 9; f++) chk($sformatf("auto_seq%0d", f), 32'(seq_obs[f]), 32'(seq_exp[f]));

    // Blanking: digits 0 and 2 dark, anodes still scanned.
    AutoMode   = 1'b0;
    SelectCode = 2'd0;
    ChannelData[15:0] = 16'h8888;
    BlankMask  = 4'b0101;
    finish_frame();
    digit_step("bl_d0");
    chk("bl_d0_seg", 32'(SegOut), 32'hFF);
    chk("bl_d0_bits", 32'(Bits), 32'hE);
    digit_step("bl_d1");
    chk("bl_d1_seg", 32'(SegOut), 32'h80);
    digit_step("bl_d2");
    chk("bl_d2_seg", 32'(SegOut), 32'hFF);
    chk("bl_d2_bits", 32'(Bits), 32'hB);
    digit_step("bl_d3");
    chk("bl_d3_seg", 32'(SegOut), 32'h80);

    // Asynchronous reset during digit 2.
    BlankMask = '0;
    finish_frame();
    digit_step("mr_d0");
    digit_step("mr_d1");
    digit_step("mr_d2");
    @(posedge CLK);
    #2 Reset = 1'b1;
    #1;
    chk("mr_seg", 32'(SegOut), 32'hFF);
    chk("mr_bits", 32'(Bits), 32'hF);
    chk("mr_cur", 32'(CurChannel), 32'h0);
    chk("mr_ft", 32'(FrameTick), 32'h0);
    repeat (2) @(posedge CLK);
    ChannelData = {$urandom, $urandom};
    ChannelData[31:16] = 16'h12AF;
    SelectCode = 2'd1;
    @(posedge CLK);
    #1 Reset = 1'b0;
    model_reset();
    digit_step("rs_d0");
    chk("rs_d0_seg", 32'(SegOut), 32'h8E);
    chk("rs_d0_bits", 32'(Bits), 32'hE);
    // Three-channel instance: select 3 is out of range, so channel 0 is shown.
    chk("c3_cur", 32'(cur3), 32'h0);
    chk("c3_ft", 32'(ft3), 32'h1);
    chk("c3_bits", 32'(bits3), 32'hE);
    chk("c3_d0_seg", 32'(seg3), 32'({1'b0, hex7[cd3[3:0]]}));
    digit_step("rs_d1");
    chk("rs_d1_seg", 32'(SegOut), 32'h08);
    chk("c3_d1_seg", 32'(seg3), 32'({1'b1, hex7[cd3[7:4]]}));
    digit_step("rs_d2");
    chk("rs_d2_seg", 32'(SegOut), 32'hA4);
    digit_step("rs_d3");
    chk("rs_d3_seg", 32'(SegOut), 32'hF9);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
